// File: rtl/simd_product_accumulator.sv
// rtl/simd_product_accumulator.sv - two-lane product accumulator with optional saturation
//
// Purpose:
//   Sums a programmed number of unsigned product pairs, one pair per valid
//   beat, into two independent accumulators. It flags overflow per lane and
//   pulses done_o for one cycle once the final sums are on acc0_o/acc1_o.
//
// Ports:
//   clock_i    in   1       rising-edge clock
//   reset_i    in   1       asynchronous active-high reset
//   start_i    in   1       begin a run (honoured only in IDLE)
//   len_i      in   LEN_W   number of valid product pairs in the run
//   z_valid_i  in   1       z0_i/z1_i carry a valid pair this cycle
//   z0_i       in   PROD_W  lane 0 unsigned product
//   z1_i       in   PROD_W  lane 1 unsigned product
//   busy_o     out  1       high in ACCUM and DONE
//   done_o     out  1       one-cycle pulse, accumulators final
//   acc0_o     out  ACC_W   lane 0 accumulator (registered)
//   acc1_o     out  ACC_W   lane 1 accumulator (registered)
//   ovf0_o     out  1       sticky lane 0 overflow for current/last run
//   ovf1_o     out  1       sticky lane 1 overflow for current/last run

module simd_product_accumulator #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              z_valid_i,
  input  logic [PROD_W-1:0] z0_i,
  input  logic [PROD_W-1:0] z1_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ACC_W-1:0]  acc0_o,
  output logic [ACC_W-1:0]  acc1_o,
  output logic              ovf0_o,
  output logic              ovf1_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] count;

  // One extra bit on the sum captures the carry-out that marks overflow.
  logic [ACC_W:0]   sum0;
  logic [ACC_W:0]   sum1;
  logic [ACC_W-1:0] acc0_next;
  logic [ACC_W-1:0] acc1_next;

  always_comb begin
    sum0 = {1'b0, acc0_o} + {{(ACC_W + 1 - PROD_W){1'b0}}, z0_i};
    sum1 = {1'b0, acc1_o} + {{(ACC_W + 1 - PROD_W){1'b0}}, z1_i};
    // With saturation, a clamped lane sits at all-ones; any later non-zero
    // sample carries again and keeps it clamped for the rest of the run.
    if (SATURATE && sum0[ACC_W]) begin
      acc0_next = '1;
    end else begin
      acc0_next = sum0[ACC_W-1:0];
    end
    if (SATURATE && sum1[ACC_W]) begin
      acc1_next = '1;
    end else begin
      acc1_next = sum1[ACC_W-1:0];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= S_IDLE;
      count  <= '0;
      acc0_o <= '0;
      acc1_o <= '0;
      ovf0_o <= 1'b0;
      ovf1_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // A z_valid_i that coincides with the accepted start is not summed.
          if (start_i) begin
            acc0_o <= '0;
            acc1_o <= '0;
            ovf0_o <= 1'b0;
            ovf1_o <= 1'b0;
            if (len_i != '0) begin
              count <= len_i;
              state <= S_ACCUM;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_ACCUM: begin
          if (z_valid_i) begin
            acc0_o <= acc0_next;
            acc1_o <= acc1_next;
            ovf0_o <= ovf0_o | sum0[ACC_W];
            ovf1_o <= ovf1_o | sum1[ACC_W];
            count  <= count - LEN_W'(1);
            if (count == LEN_W'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register, so no input reaches these.
  assign busy_o = (state == S_ACCUM) || (state == S_DONE);
  assign done_o = (state == S_DONE);

endmodule

// File: doc/simd_product_accumulator.md
Name: simd_product_accumulator

Overview:
- Downstream consumer of a two-lane SIMD 8x8 unsigned multiplier pair: dsp_t1 in 10x9x32 mode, registered inputs, z outputs 16 bit.
- Accumulates a programmed number of product samples per lane into two independent wide accumulators.
- Applies optional saturation and flags overflow.
- Presents final sums with a one-cycle done pulse to the next stage, e.g. a dot-product or filter output writer.

Parameters:
- PROD_W, 16, width of each lane product input (z0_i/z1_i)
- ACC_W, 32, width of each lane accumulator/output; legal range PROD_W+1..48
- LEN_W, 8, width of the sample-count input
- SATURATE, 1, 1 = clamp at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin new accumulation run (honoured only in IDLE)
- len_i  in  LEN_W  number of valid product pairs in the run; sampled with start_i
- z_valid_i  in  1  z0_i/z1_i carry a valid product pair this cycle
- z0_i  in  PROD_W  lane 0 unsigned product
- z1_i  in  PROD_W  lane 1 unsigned product
- busy_o  out  1  high in ACCUM and DONE
- done_o  out  1  one-cycle pulse: acc outputs final
- acc0_o  out  ACC_W  lane 0 accumulator
- acc1_o  out  ACC_W  lane 1 accumulator
- ovf0_o  out  1  sticky lane 0 overflow for current/last run
- ovf1_o  out  1  sticky lane 1 overflow for current/last run

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port clock_i, reset port reset_i.
- Reset, including mid-run: state=IDLE; all outputs 0 (busy_o, done_o, acc0_o, acc1_o, ovf0_o, ovf1_o); remaining-count=0. Any in-flight run is discarded with no done_o.
- FSM states: IDLE, ACCUM, DONE.
- IDLE + start_i, len_i>0: clear acc0/acc1 and ovf0/ovf1; load count=len_i; go to ACCUM next cycle.
- IDLE + start_i, len_i=0: clear acc and ovf; go to DONE next cycle, so done_o rises with acc=0.
- IDLE, no start_i: hold acc/ovf from the last run (readable indefinitely).
- ACCUM + z_valid_i:
  - acc_n <= acc_n + zero-extended z_n_i, both lanes in the same cycle.
  - count decrements.
  - If count was 1, go to DONE next cycle.
- ACCUM, z_valid_i low: hold; no timeout.
- DONE: done_o=1 for exactly this cycle, with acc_o already holding the final sum. Unconditionally return to IDLE next cycle.
- Latency: last valid sample at cycle k gives the final acc_o and done_o=1 at k+1, and IDLE at k+2. The earliest new start_i is accepted at k+2.
- Ignored inputs:
  - start_i in ACCUM or DONE.
  - z_valid_i in IDLE or DONE, including a z_valid_i coincident with the accepted start_i.
- Arithmetic: unsigned. The sum is computed at ACC_W+1 bits; carry-out sets ovf_n (sticky until next accepted start).
  - SATURATE=1: acc_n <= all-ones on carry, and remains all-ones for the rest of the run.
  - SATURATE=0: acc_n <= low ACC_W bits.
- Lanes are independent: overflow on one lane does not affect the other.
- acc_o are direct register outputs; no combinational path from inputs to outputs.

Test Plan:
- Basic run: reset; start_i=1, len_i=4; then 4 valid cycles with (z0,z1)=(10,1),(20,2),(30,3),(40,4) → done_o pulses one cycle after the 4th valid, with acc0_o=100, acc1_o=10, ovf=0. busy_o=1 from the cycle after start through the done cycle.
- Gapped valids and ignores: len_i=3, valid pattern 1,0,0,1,0,1 with z0=255 each → acc0_o=765 at done.
  - A start_i pulsed mid-run has no effect.
  - A z_valid_i with z0=9 in the cycle after done does not alter acc0_o=765.
- Zero length: start_i with len_i=0 → done_o the next cycle, acc0_o=acc1_o=0; then IDLE.
- Overflow, ACC_W=20, 17 samples of z0=0xFFFF (sum 1114095):
  - SATURATE=1 → acc0_o=0xFFFFF, ovf0_o=1.
  - SATURATE=0 → acc0_o=0x0FFEF, ovf0_o=1.
  - Lane 1 fed with 1s gives acc1_o=17, ovf1_o=0.
  - The next start clears both ovf flags.
- Reset mid-run: len_i=8; after 3 valid samples assert reset_i asynchronously between edges → all outputs 0 immediately, no done_o. After release, a new len_i=2 run of (5,6),(7,8) gives acc0_o=12, acc1_o=14.
- Back-to-back: start accepted at k+2 after a done at k+1 → new run clears acc and produces correct sums; acc from the previous run is held until that start.
